// File: rtl/direction_input_ctrl.sv
// Button front end for the 2048 core: synchronizes and debounces four buttons,
// rejects chords, and issues one one-hot direction command per press.
module direction_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic [1:0]  game_state,
   input  logic        ready,
   output logic [3:0]  direction,
   output logic [15:0] move_count
);
   // state        | meaning
   // IDLE         | waiting for a single button
   // DEBOUNCE     | single button seen, counting stable samples
   // ISSUE        | command presented, waiting for ready or withdraw
   // WAIT_RELEASE | waiting for all buttons stably released

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0] GS_PLAYING = 2'b01;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      DEBOUNCE     = 2'd1,
      ISSUE        = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    sync1_q, sync1_d;
   logic [3:0]    sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    cap_q, cap_d;
   logic [3:0]    direction_q, direction_d;
   logic [15:0]   move_count_q, move_count_d;
   logic [3:0]    sync_btn;
   logic          one_hot;

   assign sync1_d  = {btn_right, btn_left, btn_down, btn_up};
   assign sync_btn = sync2_q;
   assign one_hot  = (sync_btn != 4'd0) && ((sync_btn & (sync_btn - 4'd1)) == 4'd0);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cap_d        = cap_q;
      move_count_d = move_count_q;
      unique case (state_q)
         IDLE: begin
            if (one_hot) begin
               cap_d   = sync_btn;
               cnt_d   = CW'(1);
               state_d = DEBOUNCE;
            end else if (sync_btn != 4'd0) begin
               cnt_d   = '0;
               state_d = WAIT_RELEASE;
            end
         end
         DEBOUNCE: begin
            if (sync_btn != cap_q) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               // Clear so the release window always spans a full debounce period
               cnt_d   = '0;
               state_d = (game_state == GS_PLAYING) ? ISSUE : WAIT_RELEASE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ISSUE: begin
            if (game_state != GS_PLAYING) begin
               state_d = WAIT_RELEASE;
            end else if (ready && (direction_q != 4'd0)) begin
               if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
               state_d = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (sync_btn != 4'd0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      direction_d = (state_d == ISSUE) ? cap_d : 4'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sync1_q      <= '0;
         sync2_q      <= '0;
         cnt_q        <= '0;
         cap_q        <= '0;
         direction_q  <= '0;
         move_count_q <= '0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync1_q;
         cnt_q        <= cnt_d;
         cap_q        <= cap_d;
         direction_q  <= direction_d;
         move_count_q <= move_count_d;
      end
   end

   assign direction  = direction_q;
   assign move_count = move_count_q;

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Scoreboard bench for direction_input_ctrl with DEBOUNCE_CYCLES = 4.
module tb_direction_input_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic [1:0]  game_state = 2'b01;
   logic        ready = 1'b1;
   logic [3:0]  direction;
   logic [15:0] move_count;

   typedef struct {
      logic [3:0]  dir;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          n_pass = 0;
   int          n_total = 0;
   logic        pend = 1'b0;
   logic [15:0] pend_cnt = '0;

   direction_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .game_state (game_state),
      .ready      (ready),
      .direction  (direction),
      .move_count (move_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] d, input logic [15:0] c);
      exp_t e;
      e.dir = d;
      e.cnt = c;
      exp_q.push_back(e);
   endtask

   // Monitor: every handshake transfer pops one expected command
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pend) begin
            check("count_after", {16'd0, move_count}, {16'd0, pend_cnt});
            pend = 1'b0;
         end
         if (!rst && direction != 4'd0) begin
            check("onehot", $countones(direction), 1);
            if (ready && game_state == 2'b01) begin
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_cmd: got %b expected none (t=%0t)", direction, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("cmd_dir", {28'd0, direction}, {28'd0, e.dir});
                  pend     = 1'b1;
                  pend_cnt = e.cnt;
               end
            end
         end
      end
   end

   initial begin
      tick(3);
      check("rst_dir", {28'd0, direction}, 0);
      check("rst_cnt", {16'd0, move_count}, 0);
      rst = 1'b0;

      // basic press: left held from before edge 0
      push(4'b0100, 16'd1);
      btn_left = 1'b1;
      tick(5);
      check("basic_pre", {28'd0, direction}, 0);
      tick(1);
      check("basic_dir", {28'd0, direction}, 32'b0100);
      tick(1);
      check("basic_drop", {28'd0, direction}, 0);
      check("basic_cnt", {16'd0, move_count}, 1);
      tick(20);
      btn_left = 1'b0;
      tick(20);

      // backpressure
      ready = 1'b0;
      push(4'b1000, 16'd2);
      btn_right = 1'b1;
      tick(6);
      for (int i = 0; i < 10; i++) begin
         check("bp_hold", {28'd0, direction}, 32'b1000);
         tick(1);
      end
      ready = 1'b1;
      check("bp_hold_last", {28'd0, direction}, 32'b1000);
      tick(1);
      check("bp_drop", {28'd0, direction}, 0);
      check("bp_cnt", {16'd0, move_count}, 2);
      btn_right = 1'b0;
      tick(20);

      // bounce on up, then hold
      for (int i = 0; i < 10; i++) begin
         btn_up = (i % 2 == 0);
         tick(2);
      end
      push(4'b0001, 16'd3);
      btn_up = 1'b1;
      tick(5);
      check("bounce_pre", {28'd0, direction}, 0);
      tick(1);
      check("bounce_dir", {28'd0, direction}, 32'b0001);
      tick(15);
      btn_up = 1'b0;
      tick(20);

      // chord, then press while not playing
      btn_up = 1'b1;
      btn_right = 1'b1;
      tick(20);
      btn_up = 1'b0;
      btn_right = 1'b0;
      tick(20);
      check("chord_cnt", {16'd0, move_count}, 3);
      game_state = 2'b00;
      btn_down = 1'b1;
      tick(20);
      check("gate_cnt", {16'd0, move_count}, 3);
      btn_down = 1'b0;
      tick(20);

      // withdraw by lose state
      game_state = 2'b01;
      ready = 1'b0;
      btn_down = 1'b1;
      tick(6);
      check("wd_dir", {28'd0, direction}, 32'b0010);
      game_state = 2'b11;
      tick(1);
      check("wd_drop", {28'd0, direction}, 0);
      check("wd_cnt", {16'd0, move_count}, 3);
      btn_down = 1'b0;
      tick(20);

      // ready and non-playing in the same cycle: withdraw wins
      game_state = 2'b01;
      btn_left = 1'b1;
      tick(6);
      check("wd2_dir", {28'd0, direction}, 32'b0100);
      ready = 1'b1;
      game_state = 2'b10;
      tick(1);
      check("wd2_drop", {28'd0, direction}, 0);
      check("wd2_cnt", {16'd0, move_count}, 3);
      btn_left = 1'b0;
      game_state = 2'b01;
      tick(20);

      // saturation from a preloaded count
      force dut.move_count_q = 16'hFFFE;
      tick(1);
      release dut.move_count_q;
      tick(1);
      check("sat_preload", {16'd0, move_count}, 32'hFFFE);
      push(4'b0100, 16'hFFFF);
      btn_left = 1'b1;
      tick(8);
      btn_left = 1'b0;
      tick(20);
      push(4'b0100, 16'hFFFF);
      btn_left = 1'b1;
      tick(8);
      check("sat_cnt", {16'd0, move_count}, 32'hFFFF);
      btn_left = 1'b0;
      tick(20);

      // reset while a command is in flight
      ready = 1'b0;
      btn_right = 1'b1;
      tick(6);
      check("rstmid_dir", {28'd0, direction}, 32'b1000);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rstmid_drop", {28'd0, direction}, 0);
      check("rstmid_cnt", {16'd0, move_count}, 0);
      ready = 1'b1;
      push(4'b1000, 16'd1);
      tick(5);
      check("rstmid_pre", {28'd0, direction}, 0);
      tick(1);
      check("rstmid_redo", {28'd0, direction}, 32'b1000);
      tick(1);
      btn_right = 1'b0;
      tick(20);

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/direction_input_ctrl.md
# direction_input_ctrl

Front-end input controller that converts four raw push-buttons into debounced, single-move direction commands for the 2048 game core. It synchronizes and debounces the buttons and rejects chords. It issues exactly one one-hot `direction` command per press through a valid/ready handshake, and requires full release before the next command. It sits between the board-level button pins and the game core's `direction` input, and is gated by the core's `game_state`.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable samples required to accept a press or a release; legal range ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw, asynchronous, active-high buttons.
- `game_state`  in  2  from core: 00 not_playing, 01 playing, 10 win, 11 lose.
- `ready`  in  1  core can accept a move this cycle.
- `direction`  out  4  one-hot move command: bit0 up, bit1 down, bit2 left, bit3 right; 0000 means no command.
- `move_count`  out  16  number of accepted moves, saturating.

## Operation
- Synchronizer: the 4-bit button vector `{right,left,down,up}` passes through two flops. The second-stage output is `sync_btn`.
- Counter: `cnt`, width $clog2(DEBOUNCE_CYCLES+1).
- Register: `cap` holds the captured one-hot vector.
- IDLE:
  - `sync_btn` == 0: stay in IDLE.
  - exactly one bit set: `cap`←`sync_btn`, `cnt`←1, go to DEBOUNCE.
  - two or more bits set (chord): `cnt`←0, go to WAIT_RELEASE.
- DEBOUNCE:
  - `sync_btn` != `cap`: `cnt`←0, go to IDLE.
  - match and `cnt` < DEBOUNCE_CYCLES-1: `cnt`++.
  - match and `cnt` == DEBOUNCE_CYCLES-1: go to ISSUE if `game_state`==01, otherwise go to WAIT_RELEASE (press dropped).
- ISSUE:
  - `direction` = `cap`.
  - Transfer occurs on the cycle where `direction`!=0 and `ready`=1. That edge: `move_count`++ (saturates at 0xFFFF), go to WAIT_RELEASE.
  - `game_state`!=01 in ISSUE while `ready`=0: command withdrawn, no count, go to WAIT_RELEASE.
  - If `ready`=1 and `game_state`!=01 in the same cycle, the withdraw rule wins (no transfer).
  - Button release during ISSUE does not cancel the command.
- WAIT_RELEASE:
  - `sync_btn`==0: `cnt`++. At `cnt`==DEBOUNCE_CYCLES-1 with `sync_btn`==0, go to IDLE, `cnt`←0.
  - `sync_btn`!=0: `cnt`←0.
- `direction` is 0000 in every state except ISSUE. It is never multi-hot.

## Timing
- Reset values: state IDLE, `direction`=0000, `move_count`=0, `cnt`=0, `cap`=0, sync flops 0.
- Reset mid-operation clears everything on the same edge, including an in-flight ISSUE.
- Latency: raw button high before edge e gives `sync_btn` valid after e+1. `direction` is asserted after edge e+1+DEBOUNCE_CYCLES.
- `direction` is registered, i.e. a state-decoded flop output.
- `direction` holds stable until transfer. It drops to 0000 after the transfer edge.
- Minimum re-issue interval after a transfer: DEBOUNCE_CYCLES release cycles + 1 IDLE cycle + DEBOUNCE_CYCLES press cycles.
- `ready` is sampled only in ISSUE and ignored elsewhere.
- `game_state` is sampled only at the DEBOUNCE→ISSUE decision and during ISSUE.

## Test plan
- Basic press (DEBOUNCE_CYCLES=4, `game_state`=01, `ready`=1): hold `btn_left` from before edge 0 → `direction`=0100 for exactly one cycle after edge 5, `move_count`=1; no further command while the button is held.
- Backpressure: as above with `ready`=0 for 10 cycles, then 1 → `direction` holds 0100 for 11 cycles, one transfer, `move_count`=1.
- Bounce: toggle `btn_up` every 2 cycles for 20 cycles, then hold → exactly one 0001 command, issued DEBOUNCE_CYCLES+2 cycles after the last toggle; no command during toggling.
- Chord and gating: hold `btn_up`+`btn_right` → no command; release and press `btn_down` with `game_state`=00 → no command, `move_count` unchanged.
- Withdraw and saturation: in ISSUE with `ready`=0, set `game_state`=11 → `direction`=0000 next cycle, count unchanged. Preloaded with 65535 accepted moves (long run), one more move → `move_count` stays 0xFFFF.
- Reset mid-ISSUE: assert `rst` one cycle while `direction`=1000 → next cycle all outputs 0, state IDLE; a held button is re-debounced from scratch.
